zpu_sd_bridge: RTL and testbench
================================

Name: zpu_sd_bridge

Overview:
- Disk-I/O bridge between the ZPU firmware register ports (ZPU_OUT2/OUT3, ZPU_RD/WR strobes, ZPU_IN2/IN3) and the hps_io SD block interface.
- Owns the 512-byte sector buffer (true dual-port) and the LBA register.
- Sequences block read/write requests with an ack timeout.
- Tracks image mount events for the firmware.
- Sits directly downstream of hps_io's SD/mount outputs and upstream of the atari5200top ZPU ports.

Parameters:
- ACK_TIMEOUT, 24'd12_000_000, clk_sys cycles to wait for sd_ack rising before abandoning a request.
- TW, 24, width of the timeout counter.

Ports:
- clk_sys  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- zpu_out2  in  32  control: [0] lba_sel, [1] block_rd level, [2] block_wr level
- zpu_out3  in  32  data from ZPU (LBA or buffer byte in [7:0])
- zpu_io_wr  in  1  ZPU_WR[5]; level, clears buffer pointer
- zpu_data_wr  in  1  ZPU_WR[6]; data write strobe
- zpu_data_rd  in  1  ZPU_RD[2]; data read strobe
- zpu_in2  out  8  status: [0] io_done, [1] mounted toggle, [4:2] fileno, [6:5] filetype, [7] readonly
- zpu_in3  out  32  lba_sel ? filesize : {24'b0, buf_q}
- io_error  out  1  last request timed out
- sd_lba  out  32  sector address to hps_io
- sd_rd  out  1  read request
- sd_wr  out  1  write request
- sd_ack  in  1  hps_io transfer acknowledge
- sd_buff_addr  in  9  hps_io buffer address
- sd_buff_dout  in  8  hps_io write data into buffer
- sd_buff_wr  in  1  hps_io buffer write enable
- sd_buff_din  out  8  buffer data to hps_io (1-cycle registered read)
- img_mounted  in  1  mount pulse/level
- img_size  in  64  image size in bytes
- ioctl_index  in  8  [7:6] give filetype

Behaviour:
- Reset values (async assert, sync deassert usage):
  - sd_rd = sd_wr = 0; sd_lba = 0; io_done = 1; io_error = 0.
  - Buffer pointer = 0; mounted = 0; fileno = 0; filetype = 0; readonly = 1; filesize = 0; timeout counter = 0; FSM = IDLE.
  - First clk_sys edge after reset release: mounted <= |img_size[31:0].
- Buffer: port A is hps_io (sd_buff_addr/dout/wr → sd_buff_din); port B is the ZPU pointer. Both ports read with 1-cycle latency.
- Data write: zpu_data_wr is sampled through two flops (w1, w2). Action fires when w1 & ~w2, i.e. 2 cycles after the strobe rises.
  - lba_sel=1: sd_lba <= zpu_out3.
  - lba_sel=0: write zpu_out3[7:0] at the pointer; pointer +1 on the following cycle.
- Data read: pointer +1 on the cycle after zpu_data_rd falls.
- zpu_io_wr high: pointer <= 0. This has priority over any same-cycle increment.
- Pointer is 9 bits and wraps 511 → 0 silently.
- FSM states: IDLE, REQ, XFER.
  - IDLE: block_rd rising edge → sd_rd=1, io_done=0, io_error=0, counter=0, go REQ.
  - IDLE: block_wr rising edge → same, but sd_wr=1.
  - IDLE: if both edges occur in the same cycle, read wins; the write edge is dropped.
  - REQ: sd_ack=1 → sd_rd = sd_wr = 0, go XFER.
  - REQ: counter == ACK_TIMEOUT-1 → drop request, io_done=1, io_error=1, go IDLE.
  - REQ: otherwise counter +1.
  - XFER: sd_ack falling → io_done=1, go IDLE.
- Edges on block_rd/block_wr seen outside IDLE are ignored. Edge-detect registers keep updating in every state.
- Mount: rising edge of img_mounted →
  - mounted toggles; fileno=0; filetype=ioctl_index[7:6]; readonly=1; filesize=img_size[31:0].
  - A mount occurring during REQ/XFER does not abort the transfer.
- Reset asserted mid-transfer: FSM returns to IDLE at once, requests drop, and no io_done pulse is generated afterward.
- zpu_in3 is combinational on lba_sel. buf_q carries the registered port-B read.

Test Plan:
- Reset release with img_size=0x4000 → zpu_in2=0x81 (readonly, io_done, mounted=0 → 1 one cycle later: 0x83); sd_rd = sd_wr = 0.
- lba_sel=1, zpu_out3=0x00000123, pulse zpu_data_wr → sd_lba=0x123 exactly 2 cycles after the rise; pointer unchanged.
- zpu_io_wr, then 3 data writes 0xAA, 0xBB, 0xCC (lba_sel=0) → hps_io port reads addr 0..2 = AA, BB, CC. Raise block_wr → sd_wr=1, io_done=0. Ack held 10 cycles → sd_wr drops on the ack cycle; io_done=1 the cycle after ack falls.
- hps_io writes 0x5A at addr 0 and 0x5B at addr 1. Then zpu_io_wr, read, falling rd strobe, read → zpu_in3[7:0] = 0x5A then 0x5B.
- ACK_TIMEOUT=16: block_rd rising with sd_ack held 0 → sd_rd high for exactly 16 cycles, then io_done=1, io_error=1. A subsequent successful read clears io_error.
- img_mounted pulse with ioctl_index=0x40, img_size=0x8000 during XFER → zpu_in2[1] toggles, [6:5]=01, filesize=0x8000 (lba_sel=1); the transfer still completes with io_done=1.

Source files
------------

// File: rtl/zpu_sd_bridge.sv
// Disk-I/O bridge between the ZPU firmware register ports and the hps_io SD block interface.
// Holds the 512-byte sector buffer, the LBA register, the block request sequencer and mount status.
module zpu_sd_bridge #(
    parameter int unsigned   TW          = 24,
    parameter logic [TW-1:0] ACK_TIMEOUT = TW'(12_000_000)
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic [31:0] zpu_out2,
    input  logic [31:0] zpu_out3,
    input  logic        zpu_io_wr,
    input  logic        zpu_data_wr,
    input  logic        zpu_data_rd,
    output logic [7:0]  zpu_in2,
    output logic [31:0] zpu_in3,
    output logic        io_error,
    output logic [31:0] sd_lba,
    output logic        sd_rd,
    output logic        sd_wr,
    input  logic        sd_ack,
    input  logic [8:0]  sd_buff_addr,
    input  logic [7:0]  sd_buff_dout,
    input  logic        sd_buff_wr,
    output logic [7:0]  sd_buff_din,
    input  logic        img_mounted,
    input  logic [63:0] img_size,
    input  logic [7:0]  ioctl_index
);

    typedef enum logic [1:0] {IDLE, REQ, XFER} state_t;

    localparam logic [TW-1:0] ACK_LAST = ACK_TIMEOUT - TW'(1);

    logic          lba_sel, block_rd, block_wr;
    logic          rd_rise, wr_rise, ack_fall, mount_rise;
    logic          wr_fire, rd_fall;

    logic [7:0]    buf_mem [512];
    logic [7:0]    buf_q, sd_buff_din_q;
    logic [8:0]    ptr_q, ptr_d;
    logic          w1_q, w2_q, rd1_q, rd2_q, inc_wr_q;
    logic          brd_q, bwr_q, ack_q, mnt_q, first_q;

    state_t        state_q;
    logic [TW-1:0] cnt_q;
    logic          sd_rd_q, sd_wr_q, io_done_q, io_error_q;
    logic [31:0]   sd_lba_q;

    logic          mounted_q, readonly_q;
    logic [2:0]    fileno_q;
    logic [1:0]    filetype_q;
    logic [31:0]   filesize_q;

    logic          unused_bits;

    assign lba_sel  = zpu_out2[0];
    assign block_rd = zpu_out2[1];
    assign block_wr = zpu_out2[2];

    assign wr_fire    = w1_q & ~w2_q;
    assign rd_fall    = rd2_q & ~rd1_q;
    assign rd_rise    = block_rd & ~brd_q;
    assign wr_rise    = block_wr & ~bwr_q;
    assign ack_fall   = ack_q & ~sd_ack;
    assign mount_rise = img_mounted & ~mnt_q;

    assign unused_bits = ^{zpu_out2[31:3], img_size[63:32], ioctl_index[5:0]};

    // NOTE: no reset on the buffer array or its read registers; a RAM macro has no reset port.
    always_ff @(posedge clk_sys) begin
        if (sd_buff_wr)
            buf_mem[sd_buff_addr] <= sd_buff_dout;
        if (wr_fire && !lba_sel)
            buf_mem[ptr_q] <= zpu_out3[7:0];
        sd_buff_din_q <= buf_mem[sd_buff_addr];
        buf_q         <= buf_mem[ptr_q];
    end

    // NOTE: default assignment first so every path assigns ptr_d and no latch is inferred.
    always_comb begin
        ptr_d = ptr_q;
        if (zpu_io_wr)
            ptr_d = '0;
        else if (inc_wr_q || rd_fall)
            ptr_d = ptr_q + 9'd1;
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            ptr_q    <= '0;
            w1_q     <= 1'b0;
            w2_q     <= 1'b0;
            rd1_q    <= 1'b0;
            rd2_q    <= 1'b0;
            inc_wr_q <= 1'b0;
            sd_lba_q <= '0;
        end else begin
            ptr_q    <= ptr_d;
            w1_q     <= zpu_data_wr;
            w2_q     <= w1_q;
            rd1_q    <= zpu_data_rd;
            rd2_q    <= rd1_q;
            inc_wr_q <= wr_fire & ~lba_sel;
            if (wr_fire && lba_sel)
                sd_lba_q <= zpu_out3;
        end
    end

    // Block request sequencer; edge detectors track their inputs in every state.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            sd_rd_q    <= 1'b0;
            sd_wr_q    <= 1'b0;
            io_done_q  <= 1'b1;
            io_error_q <= 1'b0;
            brd_q      <= 1'b0;
            bwr_q      <= 1'b0;
            ack_q      <= 1'b0;
        end else begin
            brd_q <= block_rd;
            bwr_q <= block_wr;
            ack_q <= sd_ack;
            unique case (state_q)
                IDLE: begin
                    if (rd_rise || wr_rise) begin
                        sd_rd_q    <= rd_rise;
                        sd_wr_q    <= ~rd_rise;
                        io_done_q  <= 1'b0;
                        io_error_q <= 1'b0;
                        cnt_q      <= '0;
                        state_q    <= REQ;
                    end
                end
                REQ: begin
                    if (sd_ack) begin
                        sd_rd_q <= 1'b0;
                        sd_wr_q <= 1'b0;
                        state_q <= XFER;
                    end else if (cnt_q == ACK_LAST) begin
                        sd_rd_q    <= 1'b0;
                        sd_wr_q    <= 1'b0;
                        io_done_q  <= 1'b1;
                        io_error_q <= 1'b1;
                        state_q    <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + TW'(1);
                    end
                end
                XFER: begin
                    if (ack_fall) begin
                        io_done_q <= 1'b1;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Mount tracking; the first cycle after reset seeds 'mounted' from the current image size.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            first_q    <= 1'b1;
            mnt_q      <= 1'b0;
            mounted_q  <= 1'b0;
            fileno_q   <= '0;
            filetype_q <= '0;
            readonly_q <= 1'b1;
            filesize_q <= '0;
        end else begin
            first_q <= 1'b0;
            mnt_q   <= img_mounted;
            if (first_q)
                mounted_q <= |img_size[31:0];
            else if (mount_rise)
                mounted_q <= ~mounted_q;
            if (mount_rise) begin
                fileno_q   <= '0;
                filetype_q <= ioctl_index[7:6];
                readonly_q <= 1'b1;
                filesize_q <= img_size[31:0];
            end
        end
    end

    assign zpu_in2     = {readonly_q, filetype_q, fileno_q, mounted_q, io_done_q};
    assign zpu_in3     = lba_sel ? filesize_q : {24'b0, buf_q};
    assign io_error    = io_error_q;
    assign sd_lba      = sd_lba_q;
    assign sd_rd       = sd_rd_q;
    assign sd_wr       = sd_wr_q;
    assign sd_buff_din = sd_buff_din_q;

endmodule

// File: tb/tb_zpu_sd_bridge.sv
// Directed testbench for zpu_sd_bridge: expected values are queued as stimulus is driven
// and popped when the corresponding DUT output is sampled.
module tb_zpu_sd_bridge;

    localparam int unsigned   TW          = 24;
    localparam logic [TW-1:0] ACK_TIMEOUT = 24'd16;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic [31:0] zpu_out2, zpu_out3;
    logic        zpu_io_wr, zpu_data_wr, zpu_data_rd;
    logic [7:0]  zpu_in2;
    logic [31:0] zpu_in3;
    logic        io_error;
    logic [31:0] sd_lba;
    logic        sd_rd, sd_wr, sd_ack;
    logic [8:0]  sd_buff_addr;
    logic [7:0]  sd_buff_dout, sd_buff_din;
    logic        sd_buff_wr;
    logic        img_mounted;
    logic [63:0] img_size;
    logic [7:0]  ioctl_index;

    zpu_sd_bridge #(.TW(TW), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
        .clk_sys      (clk_sys),
        .reset        (reset),
        .zpu_out2     (zpu_out2),
        .zpu_out3     (zpu_out3),
        .zpu_io_wr    (zpu_io_wr),
        .zpu_data_wr  (zpu_data_wr),
        .zpu_data_rd  (zpu_data_rd),
        .zpu_in2      (zpu_in2),
        .zpu_in3      (zpu_in3),
        .io_error     (io_error),
        .sd_lba       (sd_lba),
        .sd_rd        (sd_rd),
        .sd_wr        (sd_wr),
        .sd_ack       (sd_ack),
        .sd_buff_addr (sd_buff_addr),
        .sd_buff_dout (sd_buff_dout),
        .sd_buff_wr   (sd_buff_wr),
        .sd_buff_din  (sd_buff_din),
        .img_mounted  (img_mounted),
        .img_size     (img_size),
        .ioctl_index  (ioctl_index)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb_q[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    task automatic sb_push(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb_q.push_back(e);
    endtask

    task automatic check(input logic [31:0] observed);
        exp_t e;
        n_assert++;
        if (sb_q.size() == 0) begin
            n_fail++;
            $error("FAIL sb_empty: observed %0h, no expected value queued", observed);
        end else begin
            e = sb_q.pop_front();
            assert (observed === e.val) else begin
                n_fail++;
                $error("FAIL %s: observed %0h expected %0h", e.tag, observed, e.val);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic zpu_write_byte(input logic [7:0] b);
        zpu_out2    = 32'd0;
        zpu_out3    = {24'd0, b};
        zpu_data_wr = 1'b1;
        tick();
        tick();
        zpu_data_wr = 1'b0;
        tick();
        tick();
        tick();
    endtask

    task automatic zpu_read_pulse();
        zpu_data_rd = 1'b1;
        tick();
        zpu_data_rd = 1'b0;
        tick();
        tick();
    endtask

    task automatic hps_write(input logic [8:0] a, input logic [7:0] d);
        sd_buff_addr = a;
        sd_buff_dout = d;
        sd_buff_wr   = 1'b1;
        tick();
        sd_buff_wr   = 1'b0;
    endtask

    task automatic hps_read_check(input string tag, input logic [8:0] a, input logic [7:0] d);
        sd_buff_addr = a;
        sd_buff_wr   = 1'b0;
        tick();
        sb_push(tag, {24'd0, d});
        check({24'd0, sd_buff_din});
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int hi;
        reset        = 1'b1;
        zpu_out2     = 32'd0;
        zpu_out3     = 32'd0;
        zpu_io_wr    = 1'b0;
        zpu_data_wr  = 1'b0;
        zpu_data_rd  = 1'b0;
        sd_ack       = 1'b0;
        sd_buff_addr = 9'd0;
        sd_buff_dout = 8'd0;
        sd_buff_wr   = 1'b0;
        img_mounted  = 1'b0;
        img_size     = 64'h4000;
        ioctl_index  = 8'd0;

        // Reset state and mount seeding
        tick();
        tick();
        sb_push("rst_in2", 32'h81);              check(32'(zpu_in2));
        sb_push("rst_sd_rd", 32'd0);             check(32'(sd_rd));
        sb_push("rst_sd_wr", 32'd0);             check(32'(sd_wr));
        sb_push("rst_lba", 32'd0);               check(sd_lba);
        reset = 1'b0;
        sb_push("rel_in2_pre", 32'h81);          check(32'(zpu_in2));
        tick();
        sb_push("rel_in2_mounted", 32'h83);      check(32'(zpu_in2));

        // LBA write: lands two edges after the strobe rises
        zpu_out2    = 32'd1;
        zpu_out3    = 32'h0000_0123;
        zpu_data_wr = 1'b1;
        tick();
        sb_push("lba_1cyc", 32'd0);              check(sd_lba);
        tick();
        sb_push("lba_2cyc", 32'h123);            check(sd_lba);
        zpu_data_wr = 1'b0;
        tick();
        tick();
        tick();

        // Pointer still at 0 after the LBA write
        zpu_write_byte(8'h11);
        hps_read_check("ptr_after_lba", 9'd0, 8'h11);

        // Pointer clear, three buffer writes, read back on the hps_io port
        zpu_io_wr = 1'b1;
        tick();
        zpu_io_wr = 1'b0;
        tick();
        zpu_write_byte(8'hAA);
        zpu_write_byte(8'hBB);
        zpu_write_byte(8'hCC);
        hps_read_check("buf0", 9'd0, 8'hAA);
        hps_read_check("buf1", 9'd1, 8'hBB);
        hps_read_check("buf2", 9'd2, 8'hCC);

        // Block write with a 10-cycle ack
        zpu_out2 = 32'd4;
        tick();
        sb_push("bw_sd_wr", 32'd1);              check(32'(sd_wr));
        sb_push("bw_io_done", 32'd0);            check(32'(zpu_in2[0]));
        tick();
        tick();
        sd_ack = 1'b1;
        tick();
        sb_push("bw_wr_drop", 32'd0);            check(32'(sd_wr));
        repeat (9) tick();
        sb_push("bw_done_during_ack", 32'd0);    check(32'(zpu_in2[0]));
        sd_ack = 1'b0;
        tick();
        sb_push("bw_done", 32'd1);               check(32'(zpu_in2[0]));
        sb_push("bw_lba", 32'h123);              check(sd_lba);
        zpu_out2 = 32'd0;
        tick();

        // ZPU-side reads of hps_io-written data
        hps_write(9'd0, 8'h5A);
        hps_write(9'd1, 8'h5B);
        hps_write(9'd511, 8'hE7);
        zpu_io_wr = 1'b1;
        tick();
        zpu_io_wr = 1'b0;
        tick();
        sb_push("rd_byte0", 32'h5A);             check(zpu_in3);
        zpu_read_pulse();
        tick();
        sb_push("rd_byte1", 32'h5B);             check(zpu_in3);

        // Walk the pointer to 511 and wrap to 0
        for (int i = 0; i < 510; i++) zpu_read_pulse();
        tick();
        sb_push("rd_byte511", 32'hE7);           check(zpu_in3);
        zpu_read_pulse();
        tick();
        sb_push("rd_wrap0", 32'h5A);             check(zpu_in3);

        // Block read with no ack: request held for ACK_TIMEOUT cycles
        zpu_out2 = 32'd2;
        tick();
        sb_push("to_sd_rd", 32'd1);              check(32'(sd_rd));
        sb_push("to_busy", 32'd0);               check(32'(zpu_in2[0]));
        hi = 1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (sd_rd) hi++;
            else break;
        end
        sb_push("to_len", 32'd16);               check(32'(hi));
        sb_push("to_io_error", 32'd1);           check(32'(io_error));
        sb_push("to_io_done", 32'd1);            check(32'(zpu_in2[0]));
        zpu_out2 = 32'd0;
        tick();

        // Successful read clears io_error; mount arrives mid-transfer
        zpu_out2 = 32'd2;
        tick();
        sb_push("rd2_sd_rd", 32'd1);             check(32'(sd_rd));
        sb_push("rd2_err_clr", 32'd0);           check(32'(io_error));
        sd_ack = 1'b1;
        tick();
        sb_push("rd2_rd_drop", 32'd0);           check(32'(sd_rd));
        ioctl_index = 8'h40;
        img_size    = 64'h8000;
        img_mounted = 1'b1;
        tick();
        img_mounted = 1'b0;
        sb_push("mnt_in2", 32'hA0);              check(32'(zpu_in2));
        zpu_out2 = 32'd3;
        #1;
        sb_push("mnt_filesize", 32'h8000);       check(zpu_in3);
        tick();
        sd_ack = 1'b0;
        tick();
        sb_push("mnt_xfer_done", 32'hA1);        check(32'(zpu_in2));
        sb_push("mnt_no_err", 32'd0);            check(32'(io_error));
        zpu_out2 = 32'd0;
        tick();

        // Reset during a pending write request
        zpu_out2 = 32'd4;
        tick();
        sb_push("rst_mid_wr_up", 32'd1);         check(32'(sd_wr));
        #2;
        reset = 1'b1;
        #1;
        sb_push("rst_mid_async", 32'd0);         check(32'(sd_wr));
        zpu_out2 = 32'd0;
        tick();
        tick();
        reset = 1'b0;
        tick();
        sb_push("rst_mid_in2", 32'h83);          check(32'(zpu_in2));
        repeat (20) tick();
        sb_push("rst_mid_idle_wr", 32'd0);       check(32'(sd_wr));
        sb_push("rst_mid_done", 32'd1);          check(32'(zpu_in2[0]));
        sb_push("rst_mid_lba", 32'd0);           check(sd_lba);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
